// File: rtl/fec_cc_encoder.sv
// Rate-1/2, K=7 tail-biting convolutional encoder (G1=171, G2=133 octal).
// Serial input bits fill one of two ping-pong banks. When a block completes,
// the encoder state is preloaded with the last six bits of that block and the
// block is replayed from the bank, one coded X/Y pair per cycle. Meanwhile the
// next block fills the other bank.
//
// Input handshake: DataIn is consumed on every rising clk edge where
// Enable=1. There is no back-pressure; input may arrive at up to one bit per
// cycle. Output handshake: DataOutX/DataOutY/BlockStart/BlockEnd are
// meaningful only while ValidOut=1, and they are held at 0 otherwise. The
// downstream side cannot stall the output.
module fec_cc_encoder #(
    parameter int BLOCK_LEN = 96
) (
    input  logic clk,
    input  logic Reset,
    input  logic Enable,
    input  logic DataIn,
    output logic DataOutX,
    output logic DataOutY,
    output logic ValidOut,
    output logic BlockStart,
    output logic BlockEnd,
    output logic fsm_state
);

    localparam int IW = $clog2(BLOCK_LEN);
    localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK_LEN - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ENCODE = 1'b1;

    logic [BLOCK_LEN-1:0] bank0;
    logic [BLOCK_LEN-1:0] bank1;
    logic [IW-1:0]        wr_idx;
    logic                 wr_bank;
    logic [IW-1:0]        rd_idx;
    logic                 rd_bank;
    logic [0:0]           state;
    // sr[0] is s1 (the most recent past bit) and sr[5] is s6.
    logic [5:0]           sr;

    logic [BLOCK_LEN-1:0] wr_word;
    logic [BLOCK_LEN-1:0] rd_word;
    logic [5:0]           preload;
    logic                 blk_done;
    logic                 active;
    logic                 u;

    assign blk_done = Enable && (wr_idx == IDX_LAST);
    assign wr_word  = wr_bank ? bank1 : bank0;
    assign rd_word  = rd_bank ? bank1 : bank0;
    assign u        = rd_word[rd_idx];
    assign active   = (state == ENCODE);

    // The tail-biting start state is b95..b90. The newest bit (b95) is still
    // on DataIn in the completing cycle, so it bypasses the bank.
    assign preload = {wr_word[BLOCK_LEN-6], wr_word[BLOCK_LEN-5],
                      wr_word[BLOCK_LEN-4], wr_word[BLOCK_LEN-3],
                      wr_word[BLOCK_LEN-2], DataIn};

    // Bank storage is not reset. A bank is only read after it is fully
    // rewritten, so stale contents never reach the output.
    always_ff @(posedge clk) begin
        if (Enable) begin
            if (wr_bank) bank1[wr_idx] <= DataIn;
            else         bank0[wr_idx] <= DataIn;
        end
    end

    // Write pointer, encode sequencing and encoder shift register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
            rd_idx  <= '0;
            rd_bank <= 1'b0;
            state   <= IDLE;
            sr      <= '0;
        end else begin
            if (Enable) begin
                if (wr_idx == IDX_LAST) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            // A completion always wins. At full input rate it coincides with
            // k=95 of the previous block, which keeps the output gapless.
            if (blk_done) begin
                state   <= ENCODE;
                rd_idx  <= '0;
                rd_bank <= wr_bank;
                sr      <= preload;
            end else if (state == ENCODE) begin
                sr <= {sr[4:0], u};
                if (rd_idx == IDX_LAST) begin
                    state  <= IDLE;
                    rd_idx <= '0;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
        end
    end

    // Coded outputs follow the registered encode state directly, so reset
    // forces them to 0 immediately.
    always_comb begin
        DataOutX   = active & (u ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5]);
        DataOutY   = active & (u ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5]);
        ValidOut   = active;
        BlockStart = active && (rd_idx == '0);
        BlockEnd   = active && (rd_idx == IDX_LAST);
        fsm_state  = state;
    end

endmodule

// File: doc/fec_cc_encoder.md
FEC_CC_ENCODER -- requirements
Module: fec_cc_encoder

Interface
REQ-001 SHALL use parameter BLOCK_LEN, default 96, meaning the number of information bits per tail-biting block (the only supported value).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port Enable, input, 1, meaning DataIn is valid this cycle (randomizer output qualifier).
REQ-005 SHALL have port DataIn, input, 1, meaning the randomized serial bit, first bit of block first.
REQ-006 SHALL have port DataOutX, output, 1, meaning the G1 = 171 (octal) coded bit.
REQ-007 SHALL have port DataOutY, output, 1, meaning the G2 = 133 (octal) coded bit.
REQ-008 SHALL have port ValidOut, output, 1, meaning DataOutX and DataOutY are valid this cycle.
REQ-009 SHALL have port BlockStart, output, 1, meaning the pulse with the first coded pair of a block.
REQ-010 SHALL have port BlockEnd, output, 1, meaning the pulse with the last (96th) coded pair of a block.

Function
REQ-011 SHALL implement a rate-1/2, K=7 tail-biting convolutional encoder, emitting one X/Y pair per cycle.
REQ-012 SHALL define the encoder state as s1..s6 (s1 = most recent past bit), and SHALL compute X = u^s1^s2^s3^s6 and Y = u^s2^s3^s5^s6, with u = the current information bit.
REQ-013 SHALL buffer input in two 96-bit banks (ping-pong), with a write index of 0..95 and the write bank toggling after index 95.
REQ-014 SHALL write DataIn to the write bank and advance the write index only when Enable=1; when Enable=0, the write index holds.
REQ-015 SHALL, in the cycle the bit at index 95 is written, load s1..s6 = b95,b94,b93,b92,b91,b90 of that block (b95 taken from DataIn), implementing the tail-biting preload.
REQ-016 SHALL implement FSM states IDLE and ENCODE: IDLE -> ENCODE on a block completion; ENCODE runs exactly 96 cycles with read index k = 0..95; ENCODE -> IDLE after k=95, unless another block completes that cycle.
REQ-017 SHALL, when a block completes in the same cycle as k=95, load the new preload state instead of the shift update and stay in ENCODE with k=0, so that output is gapless at full input rate.
REQ-018 SHALL, in ENCODE cycle k, output X/Y for u=b[k] and shift s1<=u, s(n+1)<=s(n).
REQ-019 SHALL produce its first ValidOut exactly 1 cycle after the cycle accepting bit index 95, and SHALL produce ValidOut for 96 consecutive cycles, independent of Enable.
REQ-020 SHALL assert BlockStart only at k=0 and BlockEnd only at k=95, each for 1 cycle.
REQ-021 SHALL hold DataOutX/DataOutY at 0 whenever ValidOut=0.
REQ-022 SHALL never write into the bank being encoded at an input rate of at most 1 bit/cycle; no overflow path exists.

Reset
REQ-023 SHALL, while Reset=0, force DataOutX=0, DataOutY=0, ValidOut=0, BlockStart=0, BlockEnd=0, FSM=IDLE, write index=0, write bank=0, k=0, and s1..s6=0.
REQ-024 SHALL, on reset asserted mid-fill or mid-encode, discard the partial block and any output in progress; after release, the next accepted bit is index 0.
REQ-025 SHALL NOT reset bank contents; stale bank data is never output.

Verification
REQ-026 SHALL verify: 96 zeros with Enable=1 -> 96 pairs X=0,Y=0; ValidOut first high 1 cycle after the 96th bit.
REQ-027 SHALL verify: 96 ones -> all 96 pairs X=1,Y=1.
REQ-028 SHALL verify: b0=1, rest 0 -> (X,Y) for k=0..6 = 11,10,11,11,00,01,11, and 00 for k=7..95.
REQ-029 SHALL verify: b95=1, rest 0 (tail-biting) -> (X,Y) for k=0..5 = 10,11,11,00,01,11, k=6..94 = 00, and k=95 = 11.
REQ-030 SHALL verify: two blocks back-to-back at Enable=1 every cycle -> 192 consecutive ValidOut cycles, BlockEnd at k=95 of block 1 and BlockStart on the next cycle.
REQ-031 SHALL verify: Reset pulsed low at input bit 50, then a full block -> the output corresponds to the new block only, and all outputs are 0 during reset.
